// File: rtl/vector_floating_point_add_scheduler.sv
// Two-requester round-robin issue into a fixed-latency FP add unit; results return in issue order via a credited FIFO.
// Optional stats outputs under VFPADD_SCHED_STATS_EN; rsp_ready low stalls issue once inflight + queued results reach RSP_DEPTH.
module vector_floating_point_add_scheduler #(
    parameter int  LATENCY   = 2,
    parameter int  RSP_DEPTH = 4,
    parameter int  VLEN      = 64,
    parameter type execution_vector_t = logic [9:0]
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  execution_vector_t   req0_execution_vector,
    input  logic [VLEN-1:0]     req0_vs2,
    input  logic [VLEN-1:0]     req0_vs1,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  execution_vector_t   req1_execution_vector,
    input  logic [VLEN-1:0]     req1_vs2,
    input  logic [VLEN-1:0]     req1_vs1,
    output execution_vector_t   fpadd_execution_vector,
    output logic [VLEN-1:0]     fpadd_vs2,
    output logic [VLEN-1:0]     fpadd_vs1,
    input  logic [VLEN-1:0]     fpadd_vd,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [VLEN-1:0]     rsp_vd
`ifdef VFPADD_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_issue_count,
    output logic [31:0]         stat_conflict_count,
    output logic [31:0]         stat_stall_count
`endif
);
    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = CW + IW;

    logic [LATENCY-1:0]  sr_vld;
    logic [LATENCY-1:0]  sr_id;
    logic [IW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [VLEN-1:0]     fifo_vd [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_id;
    logic                prio;
    logic [SW-1:0]       used;
    logic                credit_ok;
    logic                issue;
    logic                issue_id;
    logic                push;
    logic                pop;

    // Credits come only from registered counts, so a pop this cycle frees nothing until next cycle.
    assign used      = SW'(inflight) + SW'(fifo_count);
    assign credit_ok = used < SW'(RSP_DEPTH);

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset_n && credit_ok) begin
            if (req0_valid && (!req1_valid || !prio))
                req0_ready = 1'b1;
            else if (req1_valid)
                req1_ready = 1'b1;
        end
    end

    assign issue    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign issue_id = req1_valid && req1_ready;

    always_comb begin
        fpadd_execution_vector = '0;
        fpadd_vs2              = '0;
        fpadd_vs1              = '0;
        if (issue) begin
            fpadd_execution_vector = issue_id ? req1_execution_vector : req0_execution_vector;
            fpadd_vs2              = issue_id ? req1_vs2 : req0_vs2;
            fpadd_vs1              = issue_id ? req1_vs1 : req0_vs1;
        end
    end

    assign push      = sr_vld[LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_vd    = rsp_valid ? fifo_vd[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_vld     <= '0;
            sr_id      <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            prio       <= 1'b0;
        end else begin
            sr_vld[0] <= issue;
            sr_id[0]  <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_id[i]  <= sr_id[i-1];
            end
            inflight <= inflight + IW'(issue) - IW'(push);
            if (issue)
                prio <= !issue_id;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result storage is not reset; rsp_valid masks stale entries.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_vd[wr_ptr] <= fpadd_vd;
            fifo_id[wr_ptr] <= sr_id[LATENCY-1];
        end
    end

`ifdef VFPADD_SCHED_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_issue_count    <= '0;
            stat_conflict_count <= '0;
            stat_stall_count    <= '0;
        end else begin
            if (issue)
                stat_issue_count <= stat_issue_count + 32'd1;
            if (req0_valid && req1_valid)
                stat_conflict_count <= stat_conflict_count + 32'd1;
            if ((req0_valid || req1_valid) && !credit_ok)
                stat_stall_count <= stat_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_floating_point_add_scheduler.sv
// Directed bench for the FP add scheduler with a behavioural add unit and an in-order response scoreboard.
module tb_vector_floating_point_add_scheduler;
    localparam int LAT  = 2;
    localparam int DEP  = 4;
    localparam int VLEN = 64;

    typedef struct packed {
        logic [5:0] funct6;
        logic [2:0] frm;
        logic       vm;
    } ev_t;

    typedef struct packed {
        logic            id;
        logic [VLEN-1:0] vd;
    } sb_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    ev_t             req0_execution_vector, req1_execution_vector, fpadd_execution_vector;
    logic [VLEN-1:0] req0_vs2, req0_vs1, req1_vs2, req1_vs1;
    logic [VLEN-1:0] fpadd_vs2, fpadd_vs1, fpadd_vd;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [VLEN-1:0] rsp_vd;
`ifdef VFPADD_SCHED_STATS_EN
    logic [31:0]     stat_issue_count, stat_conflict_count, stat_stall_count;
`endif

    int  tests = 0;
    int  fails = 0;
    sb_t sbq[$];
    logic [VLEN-1:0] pipe [LAT];

    vector_floating_point_add_scheduler #(
        .LATENCY(LAT), .RSP_DEPTH(DEP), .VLEN(VLEN), .execution_vector_t(ev_t)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_execution_vector(req0_execution_vector), .req0_vs2(req0_vs2), .req0_vs1(req0_vs1),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_execution_vector(req1_execution_vector), .req1_vs2(req1_vs2), .req1_vs1(req1_vs1),
        .fpadd_execution_vector(fpadd_execution_vector), .fpadd_vs2(fpadd_vs2), .fpadd_vs1(fpadd_vs1),
        .fpadd_vd(fpadd_vd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_vd(rsp_vd)
`ifdef VFPADD_SCHED_STATS_EN
        ,
        .stat_issue_count(stat_issue_count), .stat_conflict_count(stat_conflict_count),
        .stat_stall_count(stat_stall_count)
`endif
    );

    always #5 clock = ~clock;

    // Add unit stand-in: integer sum, LAT cycles after issue.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= fpadd_vs2 + fpadd_vs1;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fpadd_vd = pipe[LAT-1];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rsp_ready = 1'b1;
        while ((sbq.size() != 0 || rsp_valid) && t < 60) begin
            cyc();
            t++;
        end
        check("drain_in_budget", t < 60, 1);
    endtask

    task automatic do_reset();
        cyc();
        reset_n = 1'b0;
        sbq.delete();
        cyc();
        reset_n = 1'b1;
    endtask

    // Issue monitor pushes the expected sum; response monitor pops and compares in order.
    always @(negedge clock) begin
        if (reset_n) begin
            check("single_grant", req0_ready & req1_ready, 0);
            if (req0_valid && req0_ready) begin
                sbq.push_back('{id: 1'b0, vd: req0_vs2 + req0_vs1});
                check("fpadd_vs2_r0", fpadd_vs2, req0_vs2);
                check("fpadd_ev_r0", fpadd_execution_vector, req0_execution_vector);
            end else if (req1_valid && req1_ready) begin
                sbq.push_back('{id: 1'b1, vd: req1_vs2 + req1_vs1});
                check("fpadd_vs1_r1", fpadd_vs1, req1_vs1);
                check("fpadd_ev_r1", fpadd_execution_vector, req1_execution_vector);
            end else begin
                check("fpadd_idle_zero", fpadd_vs2 | fpadd_vs1, 0);
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_vd", rsp_vd, e.vd);
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_execution_vector = '{funct6: 6'h00, frm: 3'd0, vm: 1'b1};
        req1_execution_vector = '{funct6: 6'h02, frm: 3'd1, vm: 1'b0};
        req0_vs2 = 64'd100; req0_vs1 = 64'd23;
        req1_vs2 = 64'h1000; req1_vs1 = 64'h0234;

        // Reset state
        at_neg();
        check("rst_req0_ready", req0_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_vd", rsp_vd, 0);
        check("rst_fpadd_vs2", fpadd_vs2, 0);
        cyc(); cyc();
        reset_n = 1'b1; req0_valid = 1'b0; rsp_ready = 1'b1;

        // Single request: response at cycle LAT+1
        cyc();
        req0_valid = 1'b1;
        at_neg();
        check("single_issue", req0_ready, 1);
        for (int k = 1; k <= LAT + 1; k++) begin
            cyc();
            req0_valid = 1'b0;
            at_neg();
            check($sformatf("single_rsp_valid_c%0d", k), rsp_valid, (k == LAT + 1));
        end
        drain();

        // Contention from reset: 0,1,0,1
        do_reset();
        cyc();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check($sformatf("rr_req0_k%0d", k), req0_ready, (k % 2 == 0));
            check($sformatf("rr_req1_k%0d", k), req1_ready, (k % 2 == 1));
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        at_neg();
`ifdef VFPADD_SCHED_STATS_EN
        check("stat_issue", stat_issue_count, 4);
        check("stat_conflict", stat_conflict_count, 4);
        check("stat_stall", stat_stall_count, 0);
`endif
        drain();

        // Backpressure: 4 credits, then stall until a pop lands
        cyc();
        rsp_ready = 1'b0; req0_valid = 1'b1; req0_vs2 = 64'd500;
        n = 0;
        for (int k = 0; k < 7; k++) begin
            logic g;
            at_neg();
            g = req0_ready;
            if (g) n++;
            cyc();
            if (g) req0_vs2 = req0_vs2 + 64'd7;
        end
        at_neg();
        check("bp_issue_count", n, 4);
        check("bp_ready_low", req0_ready, 0);
        cyc();
        rsp_ready = 1'b1;
        at_neg();
        check("bp_no_credit_same_cycle", req0_ready, 0);
        cyc();
        at_neg();
        check("bp_resume", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        drain();

        // Simultaneous push and pop at fifo_count 3
        cyc();
        rsp_ready = 1'b0; req0_valid = 1'b1; req0_vs2 = 64'd9000;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("pp_fill_issue", req0_ready, 1);
            cyc();
            req0_vs2 = req0_vs2 + 64'd3;
        end
        req0_valid = 1'b0;
        cyc(); cyc(); cyc();
        at_neg();
        check("pp_count_3", dut.fifo_count, 3);
        cyc();
        req0_valid = 1'b1;
        at_neg();
        check("pp_fourth_issue", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        rsp_ready = 1'b1;
        at_neg();
        check("pp_count_before", dut.fifo_count, 3);
        cyc();
        at_neg();
        check("pp_count_after", dut.fifo_count, 3);
        drain();

        // Mid-operation reset with two in flight; last issue was req0
        cyc();
        req1_valid = 1'b1;
        at_neg();
        check("mr_issue_r1", req1_ready, 1);
        cyc();
        req1_valid = 1'b0; req0_valid = 1'b1;
        at_neg();
        check("mr_issue_r0", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        reset_n = 1'b0;
        sbq.delete();
        at_neg();
        check("mr_rsp_valid_in_reset", rsp_valid, 0);
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            check($sformatf("mr_no_rsp_c%0d", k), rsp_valid, 0);
            cyc();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        at_neg();
        check("mr_first_req0", req0_ready, 1);
        check("mr_first_not_req1", req1_ready, 0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        check("sb_empty_at_end", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vector_floating_point_add_scheduler.md
VECTOR_FLOATING_POINT_ADD_SCHEDULER -- requirements
Module: vector_floating_point_add_scheduler

Interface
REQ-001 Parameter: LATENCY, default 2, cycles from issue to a valid result on fpadd_vd; legal range 1..8.
REQ-002 Parameter: RSP_DEPTH, default 4, response FIFO entries; power of two, at least 2.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Ports: req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 Ports: req0_ready / req1_ready  output  1  grant; the handshake completes when valid and ready are both high.
REQ-007 Ports: req0_execution_vector / req1_execution_vector  input  execution_vector_t  operation control.
REQ-008 Ports: req0_vs2, req0_vs1, req1_vs2, req1_vs1  input  VLEN  source operands.
REQ-009 Ports: fpadd_execution_vector  output  execution_vector_t, and fpadd_vs2 / fpadd_vs1  output  VLEN  operands of the granted request, '0 when nothing issues.
REQ-010 Port: fpadd_vd  input  VLEN  add-unit result, valid LATENCY cycles after issue.
REQ-011 Ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (requester index); rsp_vd  output  VLEN.

Function
REQ-012 At most one request SHALL be granted per cycle; the ready outputs SHALL be combinational from the valid inputs, the priority pointer and the credit state.
REQ-013 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted most recently wins, and the pointer updates only on an issue.
REQ-014 Issue SHALL be allowed only when inflight + fifo_count < RSP_DEPTH, so a result is never dropped.
REQ-015 A pop in the same cycle SHALL NOT free a credit for that same cycle.
REQ-016 Each issue SHALL push {valid, id} into a LATENCY-stage shift register.
REQ-017 When the shift register tail is valid, fpadd_vd and its id SHALL be written into the FIFO in that cycle.
REQ-018 inflight SHALL count the valid entries in the shift register.
REQ-019 The FIFO SHALL present its head on rsp_vd / rsp_id, with rsp_valid = (fifo_count != 0).
REQ-020 A pop SHALL occur when rsp_valid and rsp_ready are both high.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-022 A push into an empty FIFO SHALL be visible on rsp_valid the following cycle; there is no bypass path.
REQ-023 FIFO pointers SHALL wrap modulo RSP_DEPTH.
REQ-024 Results SHALL leave in issue order, regardless of id.
REQ-025 A valid request not granted SHALL keep its operands stable until granted; the scheduler does not check this.

Reset
REQ-026 On reset_n low, the following SHALL clear asynchronously: shift register, FIFO pointers, fifo_count, inflight and priority pointer (req0 favoured first).
REQ-027 During reset: rsp_valid=0, rsp_id=0, rsp_vd='0, req*_ready=0, fpadd_* ='0.
REQ-028 Operations in flight at reset SHALL be discarded without a response.

Configuration
REQ-029 With VFPADD_SCHED_STATS_EN defined, the block SHALL add three outputs:
- stat_issue_count, 32 bits, increments on every issue;
- stat_conflict_count, 32 bits, increments on each cycle where both valids are high;
- stat_stall_count, 32 bits, increments on each cycle where any valid is high but credits are exhausted.
All three SHALL wrap at 2^32 and reset to 0.
REQ-030 Without VFPADD_SCHED_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Single request: req0 alone issues at cycle 0 with rsp_ready=1 -> rsp_valid=1 with rsp_id=0 and rsp_vd equal to the unit result at cycle LATENCY+1 (cycle 3 with defaults).
REQ-032 Contention: both valids held for 4 cycles from reset -> grants in the order 0,1,0,1, and rsp_id follows the same order.
REQ-033 Backpressure: rsp_ready=0 with req0 held valid -> exactly 4 issues, then req0_ready=0.
- Raising rsp_ready then drains 4 responses in order.
- Issue resumes no earlier than one cycle after the first pop.
REQ-034 Simultaneous push and pop: with the FIFO at 3 entries and a result arriving while rsp_ready=1 -> fifo_count stays 3 and no data is lost.
REQ-035 Mid-operation reset: assert reset_n low with 2 operations in flight -> no rsp_valid pulse after release, and the first new issue is served by req0.
REQ-036 Stats build (VFPADD_SCHED_STATS_EN defined) under the REQ-032 stimulus -> stat_issue_count=4, stat_conflict_count=4 and stat_stall_count=0.
